// File: rtl/serial_data_requester.sv
// Host-side initiator for the byte-serial command protocol: sends READ/BURST/DROP
// through the UART TX handshake and captures response bytes into a local buffer.
module serial_data_requester #(
  parameter int DATA_LENGTH    = 25,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_WIDTH       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_read,
  input  logic       req_burst,
  input  logic       req_drop,
  input  logic [7:0] req_addr,
  input  logic       busy,
  output logic       new_data_tx,
  output logic [7:0] data_tx,
  input  logic       new_data_rx,
  input  logic [7:0] data_rx,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       ready,
  output logic       done,
  output logic       timeout,
  output logic [7:0] rx_count
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TX_CMD  = 3'd1;
  localparam logic [2:0] ST_TX_GAP  = 3'd2;
  localparam logic [2:0] ST_TX_ADDR = 3'd3;
  localparam logic [2:0] ST_RX_WAIT = 3'd4;

  localparam logic [7:0] CMD_READ  = 8'h04;
  localparam logic [7:0] CMD_BURST = 8'h05;
  localparam logic [7:0] CMD_DROP  = 8'h42;

  localparam logic [7:0]          BURST_LEN = 8'(DATA_LENGTH);
  localparam logic [TO_WIDTH-1:0] TO_LAST   = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_WIDTH-1:0] TO_ONE    = TO_WIDTH'(1);
  localparam logic [TO_WIDTH-1:0] TO_ZERO   = TO_WIDTH'(0);

  logic [2:0]          state_r;
  logic [7:0]          cmd_r;
  logic [7:0]          addr_r;
  logic                addr_sent_r;
  logic [TO_WIDTH-1:0] to_cnt_r;

  logic                req_any_s;
  logic [7:0]          req_cmd_s;
  logic [7:0]          rx_count_inc_s;
  logic                last_byte_s;

  // Request arbitration (burst > read > drop) and response-completion decode
  always_comb begin
    req_any_s      = 1'b0;
    req_cmd_s      = 8'h00;
    rx_count_inc_s = rx_count;
    last_byte_s    = 1'b0;
    if (req_burst) begin
      req_any_s = 1'b1;
      req_cmd_s = CMD_BURST;
    end else if (req_read) begin
      req_any_s = 1'b1;
      req_cmd_s = CMD_READ;
    end else if (req_drop) begin
      req_any_s = 1'b1;
      req_cmd_s = CMD_DROP;
    end else begin
      req_any_s = 1'b0;
      req_cmd_s = 8'h00;
    end
    if (rx_count == 8'hFF) begin
      rx_count_inc_s = 8'hFF;
    end else begin
      rx_count_inc_s = rx_count + 8'd1;
    end
    if (cmd_r == CMD_READ) begin
      last_byte_s = 1'b1;
    end else begin
      last_byte_s = (rx_count_inc_s >= BURST_LEN);
    end
  end

  // Command sequencer, TX handshake, response capture and timeout supervision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cmd_r       <= 8'h00;
      addr_r      <= 8'h00;
      addr_sent_r <= 1'b0;
      to_cnt_r    <= TO_ZERO;
      new_data_tx <= 1'b0;
      data_tx     <= 8'h00;
      wr_en       <= 1'b0;
      wr_addr     <= 8'h00;
      wr_data     <= 8'h00;
      ready       <= 1'b1;
      done        <= 1'b0;
      timeout     <= 1'b0;
      rx_count    <= 8'h00;
    end else begin
      new_data_tx <= 1'b0;
      data_tx     <= 8'h00;
      wr_en       <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // ready is low for the first IDLE cycle, so a request there is not accepted
          if (ready && req_any_s) begin
            cmd_r       <= req_cmd_s;
            addr_r      <= req_addr;
            addr_sent_r <= 1'b0;
            rx_count    <= 8'h00;
            ready       <= 1'b0;
            state_r     <= ST_TX_CMD;
          end else begin
            ready <= 1'b1;
          end
        end
        ST_TX_CMD: begin
          if (!busy) begin
            new_data_tx <= 1'b1;
            data_tx     <= cmd_r;
            state_r     <= ST_TX_GAP;
          end
        end
        ST_TX_ADDR: begin
          if (!busy) begin
            new_data_tx <= 1'b1;
            data_tx     <= addr_r;
            addr_sent_r <= 1'b1;
            state_r     <= ST_TX_GAP;
          end
        end
        ST_TX_GAP: begin
          if (cmd_r == CMD_DROP) begin
            done    <= 1'b1;
            state_r <= ST_IDLE;
          end else if ((cmd_r == CMD_READ) && !addr_sent_r) begin
            state_r <= ST_TX_ADDR;
          end else begin
            to_cnt_r <= TO_ZERO;
            state_r  <= ST_RX_WAIT;
          end
        end
        ST_RX_WAIT: begin
          // A byte arriving on the expiry cycle takes precedence over the timeout
          if (new_data_rx) begin
            wr_en    <= 1'b1;
            wr_data  <= data_rx;
            wr_addr  <= (cmd_r == CMD_READ) ? addr_r : rx_count;
            rx_count <= rx_count_inc_s;
            to_cnt_r <= TO_ZERO;
            if (last_byte_s) begin
              done    <= 1'b1;
              state_r <= ST_IDLE;
            end
          end else if (to_cnt_r == TO_LAST) begin
            timeout <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule
